regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/rv32_pkg.sv | 7 +
 rtl/regfile_scoreboard_if.sv | 26 ++
 rtl/regfile_scoreboard_reg.sv | 15 +
 rtl/regfile_scoreboard.sv | 81 ++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared architectural constants for the RV32 integer register file.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);
    typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue and writeback bundle between the issue stage and the register file.
interface regfile_scoreboard_if #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int AW   = rv32_pkg::AW
);
    logic            issue_valid, issue_ready;
    logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
    logic            issue_rs1_used, issue_rs2_used, issue_rd_we;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [AW:0]     pending_cnt;
    logic            wb_err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_we, wb_valid, wb_addr, wb_data,
        input  issue_ready, rs1_data, rs2_data, pending_cnt, wb_err
    );
    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_we, wb_valid, wb_addr, wb_data,
        output issue_ready, rs1_data, rs2_data, pending_cnt, wb_err
    );
endinterface

// File: rtl/regfile_scoreboard_reg.sv
// Write-enabled register cell with asynchronous active-high reset.
module regfile_scoreboard_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write bypass and a busy-bit scoreboard that stalls
// RAW and WAW hazards until the matching writeback arrives.
module regfile_scoreboard #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int NREG = rv32_pkg::NREG
) (
    input logic               clk,
    input logic               reset,
    regfile_scoreboard_if.slave rf
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy, busy_eff, wb_hit, set_vec;
    logic                      hazard, accept, set, clr, err_hit;
    logic [AW:0]               cnt;
    logic                      err;

    assign regs[0] = '0;
    for (genvar i = 1; i < NREG; i++) begin : g_reg
        regfile_scoreboard_reg #(.W(XLEN)) u_reg (
            .clk   (clk),
            .reset (reset),
            .we    (rf.wb_valid && (rf.wb_addr == AW'(i))),
            .d     (rf.wb_data),
            .q     (regs[i])
        );
    end

    always_comb begin
        wb_hit = '0;
        if (rf.wb_valid && rf.wb_addr != '0) wb_hit[rf.wb_addr] = 1'b1;
    end

    // A register retiring this cycle no longer blocks, so issue overlaps writeback.
    assign busy_eff = busy & ~wb_hit;
    assign hazard   = (rf.issue_rs1_used & busy_eff[rf.issue_rs1])
                    | (rf.issue_rs2_used & busy_eff[rf.issue_rs2])
                    | (rf.issue_rd_we    & busy_eff[rf.issue_rd]);
    assign rf.issue_ready = reset | ~hazard;
    assign accept   = rf.issue_valid & rf.issue_ready & ~reset;

    always_comb begin
        rf.rs1_data = regs[rf.issue_rs1];
        rf.rs2_data = regs[rf.issue_rs2];
        if (wb_hit[rf.issue_rs1]) rf.rs1_data = rf.wb_data;
        if (wb_hit[rf.issue_rs2]) rf.rs2_data = rf.wb_data;
        if (reset) begin
            rf.rs1_data = '0;
            rf.rs2_data = '0;
        end
    end

    assign set = accept & rf.issue_rd_we & (rf.issue_rd != '0);
    always_comb begin
        set_vec = '0;
        if (set) set_vec[rf.issue_rd] = 1'b1;
    end
    assign clr     = |(wb_hit & busy);
    assign err_hit = |(wb_hit & ~busy);

    // Set is ORed after the clear so a same-register set/clear leaves it busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= (busy & ~wb_hit) | set_vec;
            if (err_hit) err <= 1'b1;
            case ({set, clr})
                2'b10:   if (cnt != (AW+1)'(NREG-1)) cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rf.pending_cnt = cnt;
    assign rf.wb_err      = err;
endmodule
